// File: rtl/timer_mode_ctrl_if.sv
// Button/preset inputs and count/status outputs of the timer mode controller.
// The master side drives buttons and presets; the slave side is the controller.
interface timer_mode_ctrl_if;
    logic       btn_start;
    logic       btn_mode;
    logic       btn_clear;
    logic [5:0] preset_min;
    logic [5:0] preset_sec;
    logic [5:0] min;
    logic [5:0] sec;
    logic       mode;
    logic       running;
    logic       done;
    logic       tick;

    modport master (
        output btn_start, btn_mode, btn_clear,
        output preset_min, preset_sec,
        input  min, sec, mode, running, done, tick
    );

    modport slave (
        input  btn_start, btn_mode, btn_clear,
        input  preset_min, preset_sec,
        output min, sec, mode, running, done, tick
    );
endinterface

// File: rtl/timer_mode_ctrl.sv
// Stopwatch/countdown sequencer: run/pause/done FSM, 1 s prescaler, MM:SS count.
// Define TIMER_BTN_SYNC_EN to pass raw button levels through a 2-FF sync + edge detect.
module timer_mode_ctrl #(
    parameter int TICK_DIV = 50_000_000,
    parameter int MAX_MIN  = 59
) (
    input  logic               clk,
    input  logic               rst,
    timer_mode_ctrl_if.slave   bus
);

    localparam int              PW    = $clog2(TICK_DIV);
    localparam logic [PW-1:0]   PLAST = PW'(TICK_DIV - 1);
    localparam logic [5:0]      MAX_M = 6'(MAX_MIN);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE,
        DONE
    } state_t;

    state_t        state;
    logic [PW-1:0] presc;
    logic [5:0]    cnt_min;
    logic [5:0]    cnt_sec;
    logic          mode_q;
    logic          running_q;
    logic          done_q;
    logic          tick_q;

    logic          start_p;
    logic          mode_p;
    logic          clear_p;
    logic [5:0]    pmin;
    logic [5:0]    psec;

`ifdef TIMER_BTN_SYNC_EN
    logic [2:0] s_start;
    logic [2:0] s_mode;
    logic [2:0] s_clear;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_start <= '0;
            s_mode  <= '0;
            s_clear <= '0;
        end else begin
            s_start <= {s_start[1:0], bus.btn_start};
            s_mode  <= {s_mode[1:0], bus.btn_mode};
            s_clear <= {s_clear[1:0], bus.btn_clear};
        end
    end

    // bit 1 is the synchronised level, bit 2 its previous value
    assign start_p = s_start[1] & ~s_start[2];
    assign mode_p  = s_mode[1] & ~s_mode[2];
    assign clear_p = s_clear[1] & ~s_clear[2];
`else
    assign start_p = bus.btn_start;
    assign mode_p  = bus.btn_mode;
    assign clear_p = bus.btn_clear;
`endif

    assign pmin = (bus.preset_min > MAX_M) ? MAX_M : bus.preset_min;
    assign psec = (bus.preset_sec > 6'd59) ? 6'd59 : bus.preset_sec;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            presc     <= '0;
            cnt_min   <= '0;
            cnt_sec   <= '0;
            mode_q    <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            if (clear_p) begin
                state     <= IDLE;
                presc     <= '0;
                running_q <= 1'b0;
                done_q    <= 1'b0;
                cnt_min   <= mode_q ? pmin : 6'd0;
                cnt_sec   <= mode_q ? psec : 6'd0;
            end else begin
                case (state)
                    IDLE: begin
                        if (mode_p) begin
                            mode_q  <= ~mode_q;
                            cnt_min <= mode_q ? 6'd0 : pmin;
                            cnt_sec <= mode_q ? 6'd0 : psec;
                        end else if (start_p) begin
                            if (mode_q && cnt_min == 6'd0 && cnt_sec == 6'd0) begin
                                state  <= DONE;
                                done_q <= 1'b1;
                            end else begin
                                state     <= RUN;
                                running_q <= 1'b1;
                            end
                        end else if (mode_q) begin
                            cnt_min <= pmin;
                            cnt_sec <= psec;
                        end
                    end
                    RUN: begin
                        if (start_p) begin
                            state     <= PAUSE;
                            running_q <= 1'b0;
                        end else if (presc != PLAST) begin
                            presc <= presc + 1'b1;
                        end else begin
                            presc  <= '0;
                            tick_q <= 1'b1;
                            if (!mode_q) begin
                                if (cnt_sec == 6'd59) begin
                                    cnt_sec <= 6'd0;
                                    cnt_min <= (cnt_min == MAX_M) ? 6'd0
                                                                  : cnt_min + 6'd1;
                                end else begin
                                    cnt_sec <= cnt_sec + 6'd1;
                                end
                            end else if (cnt_sec == 6'd0) begin
                                cnt_sec <= 6'd59;
                                cnt_min <= cnt_min - 6'd1;
                            end else begin
                                cnt_sec <= cnt_sec - 6'd1;
                                // expiry shows 00:00 and raises done on this tick
                                if (cnt_min == 6'd0 && cnt_sec == 6'd1) begin
                                    state     <= DONE;
                                    running_q <= 1'b0;
                                    done_q    <= 1'b1;
                                end
                            end
                        end
                    end
                    PAUSE: begin
                        if (start_p) begin
                            state     <= RUN;
                            running_q <= 1'b1;
                        end
                    end
                    DONE: begin
                        cnt_min <= 6'd0;
                        cnt_sec <= 6'd0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.min     = cnt_min;
    assign bus.sec     = cnt_sec;
    assign bus.mode    = mode_q;
    assign bus.running = running_q;
    assign bus.done    = done_q;
    assign bus.tick    = tick_q;

endmodule
